// File: rtl/zip_vga_str_pipe_if.sv
// VGA input bundle: sync pulses, screen position, active flag and colour
// from the timing generator / pixel source into the stream packer.
interface zip_vga_str_pipe_if #(
    parameter int XW   = 10,
    parameter int YW   = 10,
    parameter int RGBW = 3
);
    logic            hsync;
    logic            vsync;
    logic [XW-1:0]   x_px;
    logic [YW-1:0]   y_px;
    logic            activevideo;
    logic [RGBW-1:0] rgb;

    modport master (
        output hsync, vsync, x_px, y_px, activevideo, rgb
    );

    modport slave (
        input hsync, vsync, x_px, y_px, activevideo, rgb
    );
endinterface

// File: rtl/zip_vga_str_pipe.sv
// Registered VGA stream zipper: packs sync/position/active/colour into one
// word, delays it DELAY stages, and derives a fill-valid flag, a frame-start
// strobe and a frame counter from the delayed stream.
module zip_vga_str_pipe #(
    parameter  int XW        = 10,
    parameter  int YW        = 10,
    parameter  int RGBW      = 3,
    parameter  int DELAY     = 1,
    parameter  int SYNC_POL  = 0,
    parameter  int BLANK_RGB = 1,
    parameter  int FCW       = 8,
    localparam int STRW      = XW + YW + RGBW + 3
) (
    input  logic                  px_clk,
    input  logic                  reset,
    zip_vga_str_pipe_if.slave     vga,
    output logic [STRW-1:0]       strVGA,
    output logic                  str_valid,
    output logic                  frame_start,
    output logic [FCW-1:0]        frame_cnt
);

    localparam int               FILLW   = $clog2(DELAY + 1);
    localparam logic [FILLW-1:0] FILL_MAX = FILLW'(DELAY);
    localparam logic             SYNC_ACT = (SYNC_POL != 0) ? 1'b1 : 1'b0;

    // Word loaded into every stage on reset: syncs idle, everything else zero.
    function automatic logic [STRW-1:0] safe_word();
        return {{RGBW{1'b0}}, {XW{1'b0}}, {YW{1'b0}}, ~SYNC_ACT, ~SYNC_ACT, 1'b0};
    endfunction

    logic [STRW-1:0]  pipe_q [DELAY];
    logic [STRW-1:0]  stage0_d;
    logic [RGBW-1:0]  rgb_field_d;
    logic [FILLW-1:0] fill_q;
    logic [FILLW-1:0] fill_d;
    logic             str_valid_q;
    logic             vs_q;
    logic [FCW-1:0]   frame_cnt_q;
    logic [FCW-1:0]   frame_cnt_d;
    logic             vs_out_s;
    logic             frame_start_s;

    // Pack the current inputs into a stream word, blanking colour outside active video.
    always_comb begin
        rgb_field_d = vga.rgb;
        if ((BLANK_RGB != 0) && !vga.activevideo) begin
            rgb_field_d = {RGBW{1'b0}};
        end else begin
            rgb_field_d = vga.rgb;
        end
        stage0_d = {rgb_field_d, vga.x_px, vga.y_px, vga.hsync, vga.vsync, vga.activevideo};
    end

    // Delay line: shift one word per cycle, flush every stage to the safe word on reset.
    always_ff @(posedge px_clk) begin
        if (reset) begin
            for (int i = 0; i < DELAY; i++) begin
                pipe_q[i] <= safe_word();
            end
        end else begin
            pipe_q[0] <= stage0_d;
            for (int i = 1; i < DELAY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    // Saturating count of edges since reset release.
    always_comb begin
        fill_d = fill_q;
        if (fill_q == FILL_MAX) begin
            fill_d = fill_q;
        end else begin
            fill_d = fill_q + FILLW'(1);
        end
    end

    // Fill tracking: valid once DELAY post-reset edges have shifted real samples to the output.
    always_ff @(posedge px_clk) begin
        if (reset) begin
            fill_q      <= {FILLW{1'b0}};
            str_valid_q <= 1'b0;
        end else begin
            fill_q      <= fill_d;
            str_valid_q <= (fill_d == FILL_MAX);
        end
    end

    assign vs_out_s      = pipe_q[DELAY-1][1];
    assign frame_start_s = str_valid_q & (vs_out_s == SYNC_ACT) & (vs_q != SYNC_ACT);

    // Next frame count: bump on each frame-start strobe, wrapping silently.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_start_s) begin
            frame_cnt_d = frame_cnt_q + FCW'(1);
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // Previous output vsync level and frame counter; reset overrides a coincident strobe.
    always_ff @(posedge px_clk) begin
        if (reset) begin
            vs_q        <= ~SYNC_ACT;
            frame_cnt_q <= {FCW{1'b0}};
        end else begin
            vs_q        <= vs_out_s;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign strVGA      = pipe_q[DELAY-1];
    assign str_valid   = str_valid_q;
    assign frame_start = frame_start_s;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_zip_vga_str_pipe.sv
// Randomised bench for zip_vga_str_pipe: two differently parameterised
// instances share one small-frame VGA stimulus and are compared every cycle
// against a sliding-window reference model built from the input history.
module tb_zip_vga_str_pipe;

    localparam int XW = 10, YW = 10, RGBW = 3, STRW = XW + YW + RGBW + 3;
    localparam int H_TOT = 20, V_TOT = 12, N_CYC = 2600;

    typedef struct {
        logic            hs, vs, act, rst;
        logic [XW-1:0]   x;
        logic [YW-1:0]   y;
        logic [RGBW-1:0] rgb;
    } samp_t;

    logic  clk = 1'b0;
    samp_t cur;
    samp_t hist[$];
    int    n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    zip_vga_str_pipe_if #(.XW(XW), .YW(YW), .RGBW(RGBW)) vga_a ();
    zip_vga_str_pipe_if #(.XW(XW), .YW(YW), .RGBW(RGBW)) vga_b ();

    assign vga_a.hsync = cur.hs;  assign vga_b.hsync = cur.hs;
    assign vga_a.vsync = cur.vs;  assign vga_b.vsync = cur.vs;
    assign vga_a.x_px  = cur.x;   assign vga_b.x_px  = cur.x;
    assign vga_a.y_px  = cur.y;   assign vga_b.y_px  = cur.y;
    assign vga_a.activevideo = cur.act; assign vga_b.activevideo = cur.act;
    assign vga_a.rgb   = cur.rgb; assign vga_b.rgb   = cur.rgb;

    logic [STRW-1:0] str_a, str_b;
    logic            val_a, val_b, fs_a, fs_b;
    logic [1:0]      cnt_a;
    logic [7:0]      cnt_b;

    zip_vga_str_pipe #(.XW(XW), .YW(YW), .RGBW(RGBW), .DELAY(4), .SYNC_POL(0),
                       .BLANK_RGB(1), .FCW(2)) dut_a (
        .px_clk(clk), .reset(cur.rst), .vga(vga_a), .strVGA(str_a),
        .str_valid(val_a), .frame_start(fs_a), .frame_cnt(cnt_a));

    zip_vga_str_pipe #(.XW(XW), .YW(YW), .RGBW(RGBW), .DELAY(1), .SYNC_POL(1),
                       .BLANK_RGB(0), .FCW(8)) dut_b (
        .px_clk(clk), .reset(cur.rst), .vga(vga_b), .strVGA(str_b),
        .str_valid(val_b), .frame_start(fs_b), .frame_cnt(cnt_b));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output after the latest edge: the sample from d-1 edges ago if no reset hit
    // any of the last d edges, otherwise the idle safe word.
    function automatic logic [STRW-1:0] exp_word(input int d, input logic pol,
                                                 input bit blank, output logic valid);
        int n;
        samp_t s;
        logic [RGBW-1:0] c;
        n = hist.size() - 1;
        valid = (n >= d - 1);
        for (int j = 0; j < d; j++) begin
            if (valid && hist[n-j].rst) valid = 1'b0;
        end
        if (!valid) return {{(STRW-3){1'b0}}, ~pol, ~pol, 1'b0};
        s = hist[n-d+1];
        c = (blank && !s.act) ? {RGBW{1'b0}} : s.rgb;
        return {c, s.x, s.y, s.hs, s.vs, s.act};
    endfunction

    int   h, v;
    logic [STRW-1:0] wa, wb;
    logic va, vb, efa, efb;
    logic prev_vs_a = 1'b1, prev_vs_b = 1'b0;
    logic fs_prev_a = 1'b0, fs_prev_b = 1'b0;
    int   ecnt_a = 0, ecnt_b = 0;

    task automatic set_inputs(input int cyc);
        cur.rst = (cyc < 2) || (cyc == 1400) || (cyc > 1800 && $urandom_range(0, 299) == 0);
        cur.x   = XW'(h);
        cur.y   = YW'(v);
        cur.act = (h < 16) && (v < 10);
        cur.hs  = !(h == 17 || h == 18);
        cur.vs  = !(v == 10);
        cur.rgb = RGBW'($urandom_range(0, 7));
    endtask

    initial begin
        h = 0;
        v = 10;                      // start inside the vsync line so it is held through reset release
        set_inputs(0);
        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            @(posedge clk);
            #1;
            hist.push_back(cur);

            wa  = exp_word(4, 1'b0, 1'b1, va);
            efa = va && (wa[1] == 1'b0) && (prev_vs_a != 1'b0);
            ecnt_a = cur.rst ? 0 : (ecnt_a + int'(fs_prev_a)) % 4;
            wb  = exp_word(1, 1'b1, 1'b0, vb);
            efb = vb && (wb[1] == 1'b1) && (prev_vs_b != 1'b1);
            ecnt_b = cur.rst ? 0 : (ecnt_b + int'(fs_prev_b)) % 256;

            check("a_strVGA",      64'(str_a), 64'(wa));
            check("a_str_valid",   64'(val_a), 64'(va));
            check("a_frame_start", 64'(fs_a),  64'(efa));
            check("a_frame_cnt",   64'(cnt_a), 64'(ecnt_a));
            check("b_strVGA",      64'(str_b), 64'(wb));
            check("b_str_valid",   64'(val_b), 64'(vb));
            check("b_frame_start", 64'(fs_b),  64'(efb));
            check("b_frame_cnt",   64'(cnt_b), 64'(ecnt_b));

            prev_vs_a = wa[1];  fs_prev_a = efa;
            prev_vs_b = wb[1];  fs_prev_b = efb;

            h = h + 1;
            if (h == H_TOT) begin
                h = 0;
                v = (v + 1) % V_TOT;
            end
            set_inputs(cyc + 1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
